ets_phase_sweeper: RTL and testbench

Sequencer for the StreamETS equivalent-time sampling path. It steps the Vernier phase index `phase_t` from a configured minimum to a configured maximum. At each step it waits for the delay line to settle, then accumulates a fixed number of ADC samples. It emits one result beat per step carrying the step index, the mapped average time from the external Vernier point map, and the sample sum.

---
 rtl/ets_phase_sweeper.sv | 176 +++++++++++++++++
 tb/tb_ets_phase_sweeper.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ets_phase_sweeper.sv
// Equivalent-time sampling sweep sequencer: steps phase_t, settles, accumulates ADC samples, emits one beat per step.
// Define ETS_ACC_SATURATE_EN to clamp the accumulator instead of wrapping it.
module ets_phase_sweeper #(
  parameter int SAMPLE_W   = 16,
  parameter int ACC_W      = 32,
  parameter int DWELL_W    = 16,
  parameter int SETTLE_CYC = 4
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                start,
  input  logic                abort,
  input  logic [6:0]          cfg_t_min,
  input  logic [6:0]          cfg_t_max,
  input  logic [DWELL_W-1:0]  cfg_dwell,
  output logic [7:0]          phase_t,
  input  logic [31:0]         map_average,
  input  logic [SAMPLE_W-1:0] s_tdata,
  input  logic                s_tvalid,
  output logic                s_tready,
  output logic [6:0]          m_t,
  output logic [31:0]         m_time,
  output logic [ACC_W-1:0]    m_sum,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic                m_tlast,
  output logic                busy,
  output logic                done,
  output logic                cfg_err,
  output logic                aborted
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_ACCUM  = 2'd2;
  localparam logic [1:0] S_EMIT   = 2'd3;

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  logic [1:0]         state;
  logic [6:0]         t_max_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [SET_W-1:0]   settle_cnt;
  logic [ACC_W-1:0]   acc;
  logic [DWELL_W-1:0] cnt;

  logic               cfg_ok;
  logic               idle_start;
  logic               take_abort;
  logic               s_hs;
  logic               m_hs;
  logic [DWELL_W-1:0] cnt_next;
  logic               last_sample;
  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   acc_next;

  // Handshake and control decode; stream ready/valid come only from the state register.
  assign s_tready = (state == S_ACCUM);
  assign m_tvalid = (state == S_EMIT);
  assign busy     = (state != S_IDLE);

  always_comb begin
    cfg_ok      = (cfg_t_min >= 7'd2) && (cfg_t_max <= 7'd120) &&
                  (cfg_t_min <= cfg_t_max) && (cfg_dwell != '0);
    idle_start  = (state == S_IDLE) && start && !abort;
    take_abort  = (state != S_IDLE) && abort;
    s_hs        = (state == S_ACCUM) && s_tvalid;
    m_hs        = (state == S_EMIT) && m_tready;
    cnt_next    = cnt + DWELL_W'(1);
    last_sample = s_hs && (cnt_next == dwell_q);
    sum_wide    = {1'b0, acc} + {1'b0, ACC_W'(s_tdata)};
`ifdef ETS_ACC_SATURATE_EN
    acc_next    = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    acc_next    = sum_wide[ACC_W-1:0];
`endif
  end

  // Sweep FSM, phase index and latched configuration.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= S_IDLE;
      phase_t    <= 8'd0;
      t_max_q    <= 7'd0;
      dwell_q    <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (idle_start && cfg_ok) begin
            state      <= S_SETTLE;
            phase_t    <= {1'b0, cfg_t_min};
            t_max_q    <= cfg_t_max;
            dwell_q    <= cfg_dwell;
            settle_cnt <= '0;
          end
        end
        S_SETTLE: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (settle_cnt == SET_LAST) begin
            state <= S_ACCUM;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        S_ACCUM: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (last_sample) begin
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (abort) begin
            state <= S_IDLE;
          end else if (m_tready) begin
            if (m_tlast) begin
              state <= S_IDLE;
            end else begin
              state      <= S_SETTLE;
              phase_t    <= phase_t + 8'd1;
              settle_cnt <= '0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Accumulator is cleared while settling so every step starts from zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      acc <= '0;
      cnt <= '0;
    end else if (state == S_SETTLE) begin
      acc <= '0;
      cnt <= '0;
    end else if (s_hs) begin
      acc <= acc_next;
      cnt <= cnt_next;
    end
  end

  // Result beat is captured on the final sample so it includes that sample.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_t     <= 7'd0;
      m_time  <= 32'd0;
      m_sum   <= '0;
      m_tlast <= 1'b0;
    end else if (last_sample && !abort) begin
      m_t     <= phase_t[6:0];
      m_time  <= map_average;
      m_sum   <= acc_next;
      m_tlast <= (phase_t[6:0] == t_max_q);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      done    <= 1'b0;
      aborted <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      done    <= m_hs && m_tlast && !abort;
      aborted <= take_abort;
      if (idle_start) begin
        cfg_err <= !cfg_ok;
      end
    end
  end

endmodule

// File: tb/tb_ets_phase_sweeper.sv
// Directed bench for ets_phase_sweeper: table of sweeps plus hand-written timing, back-pressure, abort and reset sequences.
// Build with ETS_ACC_SATURATE_EN defined to expect the clamped overflow sum.
module tb_ets_phase_sweeper;

  localparam int SAMPLE_W   = 16;
  localparam int ACC_W      = 17;
  localparam int DWELL_W    = 16;
  localparam int SETTLE_CYC = 4;

`ifdef ETS_ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] OVF_SUM = 17'h1FFFF;
`else
  localparam logic [ACC_W-1:0] OVF_SUM = 17'h1FFFC;
`endif

  logic                aclk = 1'b0;
  logic                aresetn;
  logic                start;
  logic                abort;
  logic [6:0]          cfg_t_min;
  logic [6:0]          cfg_t_max;
  logic [DWELL_W-1:0]  cfg_dwell;
  logic [7:0]          phase_t;
  logic [31:0]         map_average;
  logic [SAMPLE_W-1:0] s_tdata;
  logic                s_tvalid;
  logic                s_tready;
  logic [6:0]          m_t;
  logic [31:0]         m_time;
  logic [ACC_W-1:0]    m_sum;
  logic                m_tvalid;
  logic                m_tready;
  logic                m_tlast;
  logic                busy;
  logic                done;
  logic                cfg_err;
  logic                aborted;

  int checks = 0;
  int errors = 0;

  ets_phase_sweeper #(
    .SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W), .DWELL_W(DWELL_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort),
    .cfg_t_min(cfg_t_min), .cfg_t_max(cfg_t_max), .cfg_dwell(cfg_dwell),
    .phase_t(phase_t), .map_average(map_average),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_t(m_t), .m_time(m_time), .m_sum(m_sum), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast),
    .busy(busy), .done(done), .cfg_err(cfg_err), .aborted(aborted)
  );

  always #5 aclk = ~aclk;

  // Stand-in Vernier point map.
  function automatic logic [31:0] map_model(input logic [7:0] t);
    return 32'h1000_0000 + {24'd0, t} * 32'd37;
  endfunction

  assign map_average = map_model(phase_t);

  typedef struct {
    logic [6:0]          tmin;
    logic [6:0]          tmax;
    logic [DWELL_W-1:0]  dwell;
    logic [SAMPLE_W-1:0] s0;
    logic [SAMPLE_W-1:0] s1;
    logic [SAMPLE_W-1:0] s2;
    int                  exp_beats;
    logic [ACC_W-1:0]    exp_sum;
    logic                exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_phase_t"},  64'(phase_t),  64'd0);
    checkOutput({tag, "_m_t"},      64'(m_t),      64'd0);
    checkOutput({tag, "_m_time"},   64'(m_time),   64'd0);
    checkOutput({tag, "_m_sum"},    64'(m_sum),    64'd0);
    checkOutput({tag, "_m_tlast"},  64'(m_tlast),  64'd0);
    checkOutput({tag, "_m_tvalid"}, 64'(m_tvalid), 64'd0);
    checkOutput({tag, "_s_tready"}, 64'(s_tready), 64'd0);
    checkOutput({tag, "_busy"},     64'(busy),     64'd0);
    checkOutput({tag, "_done"},     64'(done),     64'd0);
    checkOutput({tag, "_cfg_err"},  64'(cfg_err),  64'd0);
    checkOutput({tag, "_aborted"},  64'(aborted),  64'd0);
  endtask

  // Runs one sweep with m_tready held high; samples repeat s0,s1,s2 from the start of each step.
  task automatic applyStimulus(input vec_t v);
    int beats;
    int dones;
    int step_idx;
    logic hs_s, hs_m, was_last, finished;
    logic [6:0] exp_t;
    logic [SAMPLE_W-1:0] pat[3];
    pat[0] = v.s0;
    pat[1] = v.s1;
    pat[2] = v.s2;
    beats = 0;
    dones = 0;
    step_idx = 0;
    finished = 1'b0;
    cfg_t_min = v.tmin;
    cfg_t_max = v.tmax;
    cfg_dwell = v.dwell;
    s_tdata   = pat[0];
    s_tvalid  = 1'b1;
    m_tready  = 1'b1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    cfg_t_min = 7'd0;
    cfg_t_max = 7'd0;
    cfg_dwell = '0;
    checkOutput("cfg_err", 64'(cfg_err), 64'(v.exp_err));
    checkOutput("busy_after_start", 64'(busy), 64'(!v.exp_err));
    if (v.exp_err) begin
      for (int i = 0; i < 30; i++) begin
        if (m_tvalid || s_tready) beats++;
        tick();
      end
      checkOutput("reject_beats", 64'(beats), 64'd0);
      checkOutput("reject_busy", 64'(busy), 64'd0);
    end else begin
      checkOutput("phase_t_first", 64'(phase_t), 64'({1'b0, v.tmin}));
      for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
        hs_s = s_tvalid & s_tready;
        hs_m = m_tvalid & m_tready;
        was_last = hs_m & m_tlast;
        if (hs_m) begin
          exp_t = v.tmin + 7'(beats);
          checkOutput("m_t", 64'(m_t), 64'(exp_t));
          checkOutput("m_sum", 64'(m_sum), 64'(v.exp_sum));
          checkOutput("m_time", 64'(m_time), 64'(map_model({1'b0, exp_t})));
          checkOutput("m_tlast", 64'(m_tlast), 64'(exp_t == v.tmax));
          beats++;
        end
        tick();
        if (done) dones++;
        if (was_last) begin
          checkOutput("done_after_last", 64'(done), 64'd1);
          checkOutput("busy_after_last", 64'(busy), 64'd0);
          finished = 1'b1;
        end else if (hs_m) begin
          step_idx = 0;
        end else if (hs_s) begin
          step_idx++;
        end
        s_tdata = pat[step_idx % 3];
      end
      checkOutput("sweep_finished", 64'(finished), 64'd1);
      checkOutput("beat_count", 64'(beats), 64'(v.exp_beats));
      tick();
      checkOutput("done_single_cycle", 64'(done), 64'd0);
      checkOutput("done_count", 64'(dones), 64'd1);
    end
  endtask

  initial begin
    logic seen;
    aresetn   = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    cfg_t_min = 7'd0;
    cfg_t_max = 7'd0;
    cfg_dwell = '0;
    s_tdata   = '0;
    s_tvalid  = 1'b0;
    m_tready  = 1'b0;

    vecs[0] = '{7'd2,   7'd4,   16'd3, 16'd1,      16'd2,      16'd3,      3, 17'd6,      1'b0};
    vecs[1] = '{7'd1,   7'd4,   16'd3, 16'd1,      16'd2,      16'd3,      0, 17'd0,      1'b1};
    vecs[2] = '{7'd10,  7'd5,   16'd3, 16'd1,      16'd2,      16'd3,      0, 17'd0,      1'b1};
    vecs[3] = '{7'd2,   7'd3,   16'd0, 16'd1,      16'd2,      16'd3,      0, 17'd0,      1'b1};
    vecs[4] = '{7'd120, 7'd120, 16'd5, 16'd100,    16'd200,    16'd300,    1, 17'd900,    1'b0};
    vecs[5] = '{7'd7,   7'd8,   16'd1, 16'hABCD,   16'hABCD,   16'hABCD,   2, 17'h0ABCD,  1'b0};
    vecs[6] = '{7'd3,   7'd121, 16'd2, 16'd1,      16'd2,      16'd3,      0, 17'd0,      1'b1};
    vecs[7] = '{7'd50,  7'd52,  16'd4, 16'hFFFF,   16'hFFFF,   16'hFFFF,   3, OVF_SUM,    1'b0};
    vecs[8] = '{7'd2,   7'd2,   16'd2, 16'd1,      16'd2,      16'd3,      1, 17'd3,      1'b0};

    #12;
    check_reset_state("in_reset");
    aresetn = 1'b1;
    tick();
    check_reset_state("after_reset");

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
    end

    // Step timing, back-pressure hold, then abort in the middle of ACCUM.
    cfg_t_min = 7'd5;
    cfg_t_max = 7'd6;
    cfg_dwell = 16'd2;
    s_tdata   = 16'h0010;
    s_tvalid  = 1'b1;
    m_tready  = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("seq_phase_t_start", 64'(phase_t), 64'd5);
    checkOutput("seq_settle_ready_lo", 64'(s_tready), 64'd0);
    for (int i = 0; i < SETTLE_CYC - 1; i++) tick();
    checkOutput("seq_settle_last_ready_lo", 64'(s_tready), 64'd0);
    tick();
    checkOutput("seq_accum_ready_hi", 64'(s_tready), 64'd1);
    tick();
    checkOutput("seq_mid_accum_valid_lo", 64'(m_tvalid), 64'd0);
    tick();
    checkOutput("seq_emit_valid_hi", 64'(m_tvalid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      checkOutput("bp_m_tvalid", 64'(m_tvalid), 64'd1);
      checkOutput("bp_m_t", 64'(m_t), 64'd5);
      checkOutput("bp_m_sum", 64'(m_sum), 64'h20);
      checkOutput("bp_m_time", 64'(m_time), 64'(map_model(8'd5)));
      checkOutput("bp_m_tlast", 64'(m_tlast), 64'd0);
      checkOutput("bp_s_tready", 64'(s_tready), 64'd0);
      checkOutput("bp_phase_t", 64'(phase_t), 64'd5);
      tick();
    end
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    checkOutput("resume_phase_t", 64'(phase_t), 64'd6);
    checkOutput("resume_valid_lo", 64'(m_tvalid), 64'd0);
    checkOutput("resume_busy", 64'(busy), 64'd1);
    for (int i = 0; i < SETTLE_CYC; i++) tick();
    checkOutput("resume_ready_hi", 64'(s_tready), 64'd1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_pulse", 64'(aborted), 64'd1);
    checkOutput("abort_ready", 64'(s_tready), 64'd0);
    checkOutput("abort_no_done", 64'(done), 64'd0);
    tick();
    checkOutput("abort_pulse_end", 64'(aborted), 64'd0);
    checkOutput("abort_no_done_later", 64'(done), 64'd0);

    // start and abort together in IDLE: abort wins, nothing happens.
    cfg_t_min = 7'd2;
    cfg_t_max = 7'd3;
    cfg_dwell = 16'd1;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checkOutput("idle_abort_busy", 64'(busy), 64'd0);
    checkOutput("idle_abort_no_pulse", 64'(aborted), 64'd0);
    tick();
    checkOutput("idle_abort_busy_later", 64'(busy), 64'd0);
    checkOutput("idle_abort_phase_t", 64'(phase_t), 64'd6);

    // Asynchronous reset while a beat is held in EMIT.
    cfg_t_min = 7'd9;
    cfg_t_max = 7'd9;
    cfg_dwell = 16'd1;
    s_tdata   = 16'h0005;
    s_tvalid  = 1'b1;
    m_tready  = 1'b0;
    start     = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (m_tvalid) seen = 1'b1;
      else tick();
    end
    checkOutput("emit_reached", 64'(seen), 64'd1);
    checkOutput("pre_reset_m_sum", 64'(m_sum), 64'd5);
    checkOutput("pre_reset_m_t", 64'(m_t), 64'd9);
    #2;
    aresetn = 1'b0;
    #1;
    check_reset_state("async");
    #3;
    aresetn = 1'b1;
    tick();
    checkOutput("post_reset_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
